// File: rtl/mux_arb_reg.sv
// -----------------------------------------------------------------------------
// mux_arb_reg
// Registered N-way datapath multiplexer with per-channel valid/ready handshake,
// a one-entry output register and two grant modes (external select or
// round-robin arbitration).
//
// Parameters:
//   N  number of active channels (1..4); channels with index >= N are ignored
//   X  data width of every channel and of the output
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   A,B,C,D    channel data 0..3
//   valid_in   per-channel "data present"
//   ready_in   per-channel grant this cycle (combinational, one-hot or zero)
//   s          channel select for manual mode
//   mode       0 = manual select via s, 1 = round-robin
//   out        registered output word
//   out_valid  out holds a valid word
//   out_ready  downstream accepts out this cycle
//   out_src    channel index that produced out
//   grant_cnt  four saturating 8-bit grant counters, channel i in [8i+7:8i]
//
// Optional feature macro: MUX_ARB_STATS_EN
//   defined   -> per-channel saturating grant counters are built
//   undefined -> grant_cnt is tied to zero
// -----------------------------------------------------------------------------
module mux_arb_reg #(
    parameter int N = 4,
    parameter int X = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [X-1:0] A,
    input  logic [X-1:0] B,
    input  logic [X-1:0] C,
    input  logic [X-1:0] D,
    input  logic [3:0]   valid_in,
    output logic [3:0]   ready_in,
    input  logic [1:0]   s,
    input  logic         mode,
    output logic [X-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_src,
    output logic [31:0]  grant_cnt
);

    localparam logic [2:0] N_W = 3'(N);

    logic [3:0]   chan_mask_s;
    logic [3:0]   valid_m_s;
    logic         slot_free_s;
    logic         grant_vld_s;
    logic [1:0]   grant_idx_s;
    logic         grant_s;
    logic [X-1:0] sel_data_s;
    logic [2:0]   cand_s;

    logic [X-1:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;
    logic [1:0]   out_src_q, out_src_d;
    logic [1:0]   ptr_q, ptr_d;

    // Mask off channels that are not present in this configuration.
    always_comb begin
        chan_mask_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            chan_mask_s[i] = (3'(i) < N_W);
        end
        valid_m_s   = valid_in & chan_mask_s;
        slot_free_s = !out_valid_q || out_ready;
    end

    // Grant decision: manual select or round-robin search starting at ptr.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = 2'd0;
        cand_s      = 3'd0;
        if (mode == 1'b0) begin
            // An out-of-range select yields no grant rather than a fallback channel.
            if (({1'b0, s} < N_W) && valid_m_s[s]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = s;
            end else begin
                grant_vld_s = 1'b0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                // ptr < N and k < N, so one subtraction implements the wrap.
                cand_s = {1'b0, ptr_q} + 3'(k);
                if (cand_s >= N_W) begin
                    cand_s = cand_s - N_W;
                end else begin
                    cand_s = cand_s;
                end
                if ((3'(k) < N_W) && !grant_vld_s && valid_m_s[cand_s[1:0]]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = cand_s[1:0];
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end
        grant_s = grant_vld_s && slot_free_s;
    end

    // One-hot ready toward the granted producer; forced low during reset.
    always_comb begin
        ready_in = 4'b0000;
        if (grant_s && !rst) begin
            ready_in[grant_idx_s] = 1'b1;
        end else begin
            ready_in = 4'b0000;
        end
    end

    // Data select for the granted channel.
    always_comb begin
        case (grant_idx_s)
            2'd0:    sel_data_s = A;
            2'd1:    sel_data_s = B;
            2'd2:    sel_data_s = C;
            2'd3:    sel_data_s = D;
            default: sel_data_s = A;
        endcase
    end

    // Output register and round-robin pointer next-state.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (grant_s) begin
            // Accept replaces any word draining this same cycle: no bubble.
            out_d       = sel_data_s;
            out_src_d   = grant_idx_s;
            out_valid_d = 1'b1;
            if (mode == 1'b1) begin
                if (({1'b0, grant_idx_s} + 3'd1) >= N_W) begin
                    ptr_d = 2'd0;
                end else begin
                    ptr_d = grant_idx_s + 2'd1;
                end
            end else begin
                ptr_d = ptr_q;
            end
        end else if (slot_free_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= 2'd0;
            ptr_q       <= 2'd0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

`ifdef MUX_ARB_STATS_EN
    logic [3:0][7:0] cnt_q, cnt_d;

    // Saturating per-channel grant counters.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (grant_s && (grant_idx_s == 2'(i)) && (cnt_q[i] != 8'hFF)) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Counter registers; cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`else
    assign grant_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_mux_arb_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_arb_reg
// Directed, table-driven bench for mux_arb_reg. A 4-channel and a 3-channel
// instance share the same stimulus; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_mux_arb_reg;

    logic        clk;
    logic        rst;
    logic [15:0] a_s, b_s, c_s, d_s;
    logic [3:0]  valid_in;
    logic [1:0]  sel;
    logic        mode;
    logic        out_ready;

    logic [3:0]  ready4, ready3;
    logic [15:0] out4, out3;
    logic        ov4, ov3;
    logic [1:0]  src4, src3;
    logic [31:0] gc4, gc3;

    int tests_run = 0;
    int tests_failed = 0;

    mux_arb_reg #(.N(4), .X(16)) dut4 (
        .clk(clk), .rst(rst), .A(a_s), .B(b_s), .C(c_s), .D(d_s),
        .valid_in(valid_in), .ready_in(ready4), .s(sel), .mode(mode),
        .out(out4), .out_valid(ov4), .out_ready(out_ready),
        .out_src(src4), .grant_cnt(gc4)
    );

    mux_arb_reg #(.N(3), .X(16)) dut3 (
        .clk(clk), .rst(rst), .A(a_s), .B(b_s), .C(c_s), .D(d_s),
        .valid_in(valid_in), .ready_in(ready3), .s(sel), .mode(mode),
        .out(out3), .out_valid(ov3), .out_ready(out_ready),
        .out_src(src3), .grant_cnt(gc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [1:0]  s;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  exp_ready;
        logic [15:0] exp_out;
        logic        exp_valid;
        logic [1:0]  exp_src;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

`ifdef MUX_ARB_STATS_EN
    localparam logic [31:0] EXP_CNT5   = 32'h0000_0005;
    localparam logic [31:0] EXP_CNT300 = 32'h0000_00FF;
`else
    localparam logic [31:0] EXP_CNT5   = 32'h0000_0000;
    localparam logic [31:0] EXP_CNT300 = 32'h0000_0000;
`endif

    logic [3:0]  n3_ready[4];
    logic [15:0] n3_out[4];
    logic [1:0]  n3_src[4];

    initial begin
        // mode, s, valid, out_ready | ready_in, out, out_valid, out_src
        vecs[0]  = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 16'hBBBB, 1'b1, 2'd1};
        vecs[1]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 16'hBBBB, 1'b0, 2'd1};
        vecs[2]  = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 16'hBBBB, 1'b0, 2'd1};
        vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 16'hAAAA, 1'b1, 2'd0};
        vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 16'hBBBB, 1'b1, 2'd1};
        vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 16'hCCCC, 1'b1, 2'd2};
        vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 16'hDDDD, 1'b1, 2'd3};
        vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 16'hAAAA, 1'b1, 2'd0};
        vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 16'hBBBB, 1'b1, 2'd1};
        vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 16'hCCCC, 1'b1, 2'd2};
        vecs[10] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 16'hCCCC, 1'b1, 2'd2};
        vecs[11] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 16'hCCCC, 1'b1, 2'd2};
        vecs[12] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 16'hCCCC, 1'b1, 2'd2};
        vecs[13] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 16'hDDDD, 1'b1, 2'd3};
        vecs[14] = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 16'hCCCC, 1'b1, 2'd2};
        vecs[15] = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 16'hBBBB, 1'b1, 2'd1};
        vecs[16] = '{1'b1, 2'd0, 4'b0101, 1'b1, 4'b0001, 16'hAAAA, 1'b1, 2'd0};
        vecs[17] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 16'hAAAA, 1'b0, 2'd0};
        vecs[18] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 16'hDDDD, 1'b1, 2'd3};
        vecs[19] = '{1'b1, 2'd0, 4'b1001, 1'b0, 4'b0000, 16'hDDDD, 1'b1, 2'd3};

        n3_ready[0] = 4'b0001; n3_out[0] = 16'hAAAA; n3_src[0] = 2'd0;
        n3_ready[1] = 4'b0010; n3_out[1] = 16'hBBBB; n3_src[1] = 2'd1;
        n3_ready[2] = 4'b0100; n3_out[2] = 16'hCCCC; n3_src[2] = 2'd2;
        n3_ready[3] = 4'b0001; n3_out[3] = 16'hAAAA; n3_src[3] = 2'd0;

        a_s = 16'hAAAA; b_s = 16'hBBBB; c_s = 16'hCCCC; d_s = 16'hDDDD;
        valid_in = 4'b1111; sel = 2'd0; mode = 1'b1; out_ready = 1'b1;
        rst = 1'b1;

        // Reset state, with valid_in active to prove ready_in is gated.
        #3;
        check("rst_out",   {16'h0, out4}, 32'h0);
        check("rst_valid", {31'h0, ov4}, 32'h0);
        check("rst_ready", {28'h0, ready4}, 32'h0);
        check("rst_cnt",   gc4, 32'h0);
        @(posedge clk);
        @(negedge clk);
        valid_in = 4'b0000;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_valid", {31'h0, ov4}, 32'h0);

        // Directed table on the 4-channel instance.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mode      = vecs[i].mode;
            sel       = vecs[i].s;
            valid_in  = vecs[i].valid;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d_ready", i), {28'h0, ready4}, {28'h0, vecs[i].exp_ready});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out", i),   {16'h0, out4}, {16'h0, vecs[i].exp_out});
            check($sformatf("v%0d_valid", i), {31'h0, ov4},  {31'h0, vecs[i].exp_valid});
            check($sformatf("v%0d_src", i),   {30'h0, src4}, {30'h0, vecs[i].exp_src});
        end

        // Reset mid-transfer: out_valid is high here, reset drops it with no edge.
        @(negedge clk);
        mode = 1'b1; valid_in = 4'b1111; out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out",   {16'h0, out4}, 32'h0);
        check("mid_rst_valid", {31'h0, ov4}, 32'h0);
        check("mid_rst_src",   {30'h0, src4}, 32'h0);
        check("mid_rst_ready", {28'h0, ready4}, 32'h0);
        check("mid_rst_cnt",   gc4, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // N=3 round robin with all four valid: D is never granted.
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check($sformatf("n3_%0d_ready", i), {28'h0, ready3}, {28'h0, n3_ready[i]});
            @(posedge clk);
            #1;
            check($sformatf("n3_%0d_out", i), {16'h0, out3}, {16'h0, n3_out[i]});
            check($sformatf("n3_%0d_src", i), {30'h0, src3}, {30'h0, n3_src[i]});
        end

        // Grant counters: 300 consecutive manual grants to channel A.
        @(negedge clk);
        rst = 1'b1;
        mode = 1'b0; sel = 2'd0; valid_in = 4'b0001; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("cnt_5",    gc4, EXP_CNT5);
        repeat (295) @(posedge clk);
        #1;
        check("cnt_300",  gc4, EXP_CNT300);
        check("cnt3_300", gc3, EXP_CNT300);
        check("cnt_out",  {16'h0, out4}, 32'h0000_AAAA);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
Registered, parameterised N-way datapath multiplexer that succeeds the combinational select mux. It adds per-input valid/ready handshakes, a one-entry output register and two select modes: external select, or round-robin arbitration. It sits between register-file/ALU result sources and a single downstream datapath consumer, so contention between up to four producers is resolved without glue logic.

Parameters:
N, 4, number of active inputs (1..4); inputs with index >= N are ignored and never granted.
X, 16, data width of every input and of the output.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
A  input  X  data, channel 0.
B  input  X  data, channel 1.
C  input  X  data, channel 2.
D  input  X  data, channel 3.
valid_in  input  4  bit i set = channel i presents data.
ready_in  output  4  bit i set = channel i is granted this cycle; combinational, one-hot or zero.
s  input  2  channel select, used in manual mode.
mode  input  1  0 = manual select via s; 1 = round-robin arbitration.
out  output  X  registered output data.
out_valid  output  1  out holds a valid word.
out_ready  input  1  downstream accepts out this cycle.
out_src  output  2  index of the channel that produced out.
grant_cnt  output  32  four 8-bit grant counters, channel i in bits [8i+7:8i]; see Optional Feature.

Behaviour:
- Reset (asynchronous, immediate): out=0, out_valid=0, out_src=0, rr pointer=0, grant_cnt=0. ready_in=0 while rst is high.
- slot_free = !out_valid || out_ready. No grant is issued unless slot_free.
- Manual mode (mode=0): grant channel s only if s<N and valid_in[s]=1. If s>=N there is no grant; the old "default to D" fallback does not apply.
- Round-robin mode (mode=1): search channels ptr, ptr+1, ... mod N. Grant the first one with valid_in set.
- Grant effect (same edge): out <= selected data, out_src <= granted index, out_valid <= 1. In round-robin mode, ptr <= (grant+1) mod N. In manual mode, ptr is unchanged.
- No grant while slot_free: out_valid <= 0 if out_ready was high. out and out_src hold their last values.
- Stall (out_valid=1, out_ready=0): out, out_src and out_valid hold. ready_in=0.
- Latency: data accepted on edge k appears on out after edge k, i.e. 1 cycle.
- Throughput: 1 word/cycle when out_ready is held high.
- Simultaneous drain and accept in the same cycle: the new word replaces the old one with no bubble.
- Mode change takes effect in the same cycle's grant decision. ptr is retained across mode changes.
- valid_in bits with index >= N are ignored. Their ready_in bits are always 0.
- N=1: channel A only, ptr constant 0, both modes are equivalent (in manual mode s must be 0).
- Reset mid-transfer: the pending output word is discarded and out_valid=0 immediately.

Optional Feature:
Macro MUX_ARB_STATS_EN.
- Defined: each grant to channel i increments grant_cnt[8i+7:8i]. Counters saturate at 8'hFF and clear only on rst.
- Undefined: grant_cnt is tied to 32'h0 and no counter logic is built.
- Grant behaviour is identical with or without the macro.

Test Plan:
1. Reset then idle: assert rst mid-cycle -> out=0000, out_valid=0, ready_in=0000, grant_cnt=0 with no clock edge required. Release rst, no valid_in -> out_valid stays 0.
2. Manual mode, N=4, out_ready=1: s=01, B=BBBB, valid_in=0010 -> ready_in=0010; next cycle out=BBBB, out_src=01. Then s=11, valid_in=0111 -> no grant; out_valid falls to 0.
3. Round robin, all four valid (A=AAAA, B=BBBB, C=CCCC, D=DDDD), out_ready=1 -> out sequence AAAA, BBBB, CCCC, DDDD, AAAA on consecutive cycles; out_src 0,1,2,3,0.
4. Backpressure: out_valid=1, out=CCCC, out_ready=0 for 3 cycles with all valid_in set -> out holds CCCC, ready_in=0000. Raising out_ready -> next grant is channel 3 (DDDD) on the same edge that CCCC drains.
5. N=3, round robin, valid_in=1111 -> D never granted, ready_in[3]=0; cycle order A, B, C, A.
6. With MUX_ARB_STATS_EN: 300 consecutive grants to A -> grant_cnt[7:0]=FF, other counters 0. Without the macro, the same stimulus gives grant_cnt=00000000.
